// File: rtl/fp_result_collector.sv
// fp_result_collector: registered result-collection stage for the FP ALU.
// Accepts one op select, waits for the selected arithmetic unit (or the
// comparator) to signal completion, captures its result or compare flags,
// and holds them on a valid/ready port until downstream accepts.
// Optional build macro: CMP_TIMEOUT_EN adds a WAIT-state cycle limit.
module fp_result_collector #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned NUM_UNITS      = 4,
    parameter int unsigned OP_W           = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [OP_W-1:0]            op,
    input  logic [NUM_UNITS-1:0]       unit_valid,
    input  logic [NUM_UNITS*WIDTH-1:0] unit_data,
    input  logic                       cmp_valid,
    input  logic                       cg,
    input  logic                       cl,
    input  logic                       ce,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           z,
    output logic                       gr,
    output logic                       ls,
    output logic                       eq,
    output logic [OP_W-1:0]            res_op,
    output logic                       err,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             accept;
    logic             op_bad;
    logic             is_cmp;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             strobe;
    logic             timeout;

    assign op_ready  = (state == IDLE);
    assign res_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign accept    = op_ready && op_valid;
    assign op_bad    = (op > OP_W'(NUM_UNITS));
    assign is_cmp    = (res_op == OP_W'(NUM_UNITS));
    assign strobe    = is_cmp ? cmp_valid : sel_valid;

    // Route only the latched op's unit strobe and data; other units are ignored.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (res_op == OP_W'(i)) begin
                sel_valid = unit_valid[i];
                sel_data  = unit_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef CMP_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // Count WAIT cycles since acceptance; cleared whenever a new op is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the last allowed WAIT cycle only if the strobe is absent, so a
    // strobe arriving on that same cycle still wins.
    assign timeout = (state == WAIT) && !strobe &&
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    state_nxt = op_bad ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (strobe || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers: cleared on acceptance, loaded on the selected strobe,
    // held through RESP and the following IDLE period.
    always_ff @(posedge clk) begin
        if (rst) begin
            z      <= '0;
            gr     <= 1'b0;
            ls     <= 1'b0;
            eq     <= 1'b0;
            res_op <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        res_op <= op;
                        z      <= '0;
                        gr     <= 1'b0;
                        ls     <= 1'b0;
                        eq     <= 1'b0;
                        err    <= op_bad;
                    end
                end
                WAIT: begin
                    if (strobe) begin
                        if (is_cmp) begin
                            gr <= cg;
                            ls <= cl;
                            eq <= ce;
                        end else begin
                            z <= sel_data;
                        end
                    end else if (timeout) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_result_collector.sv
// Self-checking bench for fp_result_collector: a scoreboard queue holds the
// expected result of each accepted op, popped on every res_valid/res_ready
// handshake; directed checks cover latency, back-pressure and reset.
// Build with CMP_TIMEOUT_EN defined to exercise the timeout path.
module tb_fp_result_collector;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned OP_W      = 3;
`ifdef CMP_TIMEOUT_EN
    localparam int unsigned TO_CYC    = 8;
`else
    localparam int unsigned TO_CYC    = 64;
`endif

    typedef struct {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] z;
        logic             gr;
        logic             ls;
        logic             eq;
        logic             err;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       op_valid;
    logic                       op_ready;
    logic [OP_W-1:0]            op;
    logic [NUM_UNITS-1:0]       unit_valid;
    logic [NUM_UNITS*WIDTH-1:0] unit_data;
    logic                       cmp_valid;
    logic                       cg, cl, ce;
    logic                       res_valid;
    logic                       res_ready;
    logic [WIDTH-1:0]           z;
    logic                       gr, ls, eq;
    logic [OP_W-1:0]            res_op;
    logic                       err;
    logic                       busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    fp_result_collector #(
        .WIDTH(WIDTH),
        .NUM_UNITS(NUM_UNITS),
        .OP_W(OP_W),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op(op),
        .unit_valid(unit_valid),
        .unit_data(unit_data),
        .cmp_valid(cmp_valid),
        .cg(cg),
        .cl(cl),
        .ce(ce),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .z(z),
        .gr(gr),
        .ls(ls),
        .eq(eq),
        .res_op(res_op),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int unsigned i, input logic [WIDTH-1:0] v);
        unit_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic push_exp(input logic [OP_W-1:0] o, input logic [WIDTH-1:0] zz,
                            input logic g, input logic l, input logic e, input logic er);
        exp_t x;
        x.op = o; x.z = zz; x.gr = g; x.ls = l; x.eq = e; x.err = er;
        sb.push_back(x);
    endtask

    // Present op for one cycle once the collector is ready (bounded wait).
    task automatic issue(input logic [OP_W-1:0] o);
        int unsigned n = 0;
        while (!op_ready && n < 20) begin
            tick();
            n++;
        end
        if (!op_ready) check_eq("op_ready_wait", {63'b0, op_ready}, 64'd1);
        op       = o;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    // Scoreboard: compare every delivered result with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_res", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("sb_res_op", {61'b0, res_op}, {61'b0, e.op});
                check_eq("sb_z", {32'b0, z}, {32'b0, e.z});
                check_eq("sb_gr", {63'b0, gr}, {63'b0, e.gr});
                check_eq("sb_ls", {63'b0, ls}, {63'b0, e.ls});
                check_eq("sb_eq", {63'b0, eq}, {63'b0, e.eq});
                check_eq("sb_err", {63'b0, err}, {63'b0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] pats [4];
        pats[0] = 3'b010; pats[1] = 3'b100; pats[2] = 3'b111; pats[3] = 3'b000;

        rst = 1'b1; op_valid = 1'b0; op = '0; unit_valid = '0; unit_data = '0;
        cmp_valid = 1'b0; cg = 1'b0; cl = 1'b0; ce = 1'b0; res_ready = 1'b1;
        set_slice(0, 32'h1111_1111);
        set_slice(1, 32'h4049_0FDB);
        set_slice(2, 32'h2222_2222);
        set_slice(3, 32'h3333_3333);
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_op_ready", {63'b0, op_ready}, 64'd1);
        check_eq("rst_res_valid", {63'b0, res_valid}, 64'd0);
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_z", {32'b0, z}, 64'd0);
        check_eq("rst_flags", {61'b0, gr, ls, eq}, 64'd0);
        check_eq("rst_res_op", {61'b0, res_op}, 64'd0);
        check_eq("rst_err", {63'b0, err}, 64'd0);

        // Arithmetic op 1, strobe three cycles after acceptance
        push_exp(3'd1, 32'h4049_0FDB, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(3'd1);
        check_eq("t1_busy", {63'b0, busy}, 64'd1);
        check_eq("t1_op_ready_low", {63'b0, op_ready}, 64'd0);
        tick(); tick();
        check_eq("t1_no_early_valid", {63'b0, res_valid}, 64'd0);
        unit_valid = 4'b0010;
        tick();
        unit_valid = '0;
        check_eq("t1_latency", {63'b0, res_valid}, 64'd1);
        tick();
        check_eq("t1_idle_ready", {63'b0, op_ready}, 64'd1);
        check_eq("t1_idle_valid", {63'b0, res_valid}, 64'd0);

        // Compare ops; inverted flags strobed in the acceptance cycle must be ignored
        for (int p = 0; p < 4; p++) begin
            push_exp(3'd4, 32'h0, pats[p][2], pats[p][1], pats[p][0], 1'b0);
            cmp_valid = 1'b1;
            {cg, cl, ce} = ~pats[p];
            issue(3'd4);
            cmp_valid = 1'b0;
            {cg, cl, ce} = pats[p];
            tick();
            check_eq("t2_no_accept_cycle_strobe", {63'b0, res_valid}, 64'd0);
            cmp_valid = 1'b1;
            tick();
            cmp_valid = 1'b0;
            check_eq("t2_cmp_valid", {63'b0, res_valid}, 64'd1);
            tick();
        end

        // Wrong-unit and comparator strobes ignored while waiting on unit 2
        set_slice(2, 32'hC000_0000);
        push_exp(3'd2, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(3'd2);
        unit_valid = 4'b0001;
        cmp_valid  = 1'b1;
        {cg, cl, ce} = 3'b111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t3_ignore_other", {63'b0, res_valid}, 64'd0);
        end
        unit_valid = 4'b0100;
        cmp_valid  = 1'b0;
        tick();
        unit_valid = '0;
        check_eq("t3_capture", {63'b0, res_valid}, 64'd1);
        tick();

        // Back-pressure: result held for 6 cycles, op pulses ignored
        set_slice(0, 32'h3F80_0000);
        res_ready = 1'b0;
        push_exp(3'd0, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(3'd0);
        unit_valid = 4'b0001;
        tick();
        unit_valid = '0;
        for (int i = 0; i < 6; i++) begin
            check_eq("t4_hold_valid", {63'b0, res_valid}, 64'd1);
            check_eq("t4_hold_z", {32'b0, z}, 64'h3F80_0000);
            check_eq("t4_hold_res_op", {61'b0, res_op}, 64'd0);
            check_eq("t4_op_ready_low", {63'b0, op_ready}, 64'd0);
            op_valid = (i % 2 == 0);
            op = 3'd1;
            tick();
        end
        op_valid = 1'b0;
        check_eq("t4_still_valid", {63'b0, res_valid}, 64'd1);
        res_ready = 1'b1;
        tick();
        check_eq("t4_idle_ready", {63'b0, op_ready}, 64'd1);
        check_eq("t4_z_kept_in_idle", {32'b0, z}, 64'h3F80_0000);

        // Invalid ops go straight to RESP with err
        for (int o = 5; o < 8; o++) begin
            push_exp(3'(o), 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            issue(3'(o));
            check_eq("t5_direct_resp", {63'b0, res_valid}, 64'd1);
            check_eq("t5_err", {63'b0, err}, 64'd1);
            tick();
            check_eq("t5_idle_ready", {63'b0, op_ready}, 64'd1);
        end

        // Reset during WAIT discards the transaction
        issue(3'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_res_valid", {63'b0, res_valid}, 64'd0);
        check_eq("t6_op_ready", {63'b0, op_ready}, 64'd1);
        check_eq("t6_busy", {63'b0, busy}, 64'd0);
        check_eq("t6_err", {63'b0, err}, 64'd0);
        check_eq("t6_res_op", {61'b0, res_op}, 64'd0);
        check_eq("t6_z", {32'b0, z}, 64'd0);
        unit_valid = 4'b1000;
        tick(); tick();
        unit_valid = '0;
        check_eq("t6_no_stale_valid", {63'b0, res_valid}, 64'd0);
        check_eq("t6_still_idle", {63'b0, busy}, 64'd0);

`ifdef CMP_TIMEOUT_EN
        // Timeout after 8 WAIT cycles
        push_exp(3'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'd3);
        for (int i = 0; i < 8; i++) begin
            check_eq("t7_wait_no_valid", {63'b0, res_valid}, 64'd0);
            tick();
        end
        check_eq("t7_timeout_valid", {63'b0, res_valid}, 64'd1);
        check_eq("t7_timeout_err", {63'b0, err}, 64'd1);
        tick();

        // Strobe on the 8th WAIT cycle wins over the timeout
        push_exp(3'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(3'd3);
        for (int i = 0; i < 7; i++) begin
            check_eq("t8_wait_no_valid", {63'b0, res_valid}, 64'd0);
            tick();
        end
        unit_valid = 4'b1000;
        tick();
        unit_valid = '0;
        check_eq("t8_strobe_valid", {63'b0, res_valid}, 64'd1);
        check_eq("t8_strobe_err", {63'b0, err}, 64'd0);
        tick();
`else
        // Without the timeout, WAIT holds until the strobe arrives
        push_exp(3'd3, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(3'd3);
        repeat (80) tick();
        check_eq("t7_long_wait_no_valid", {63'b0, res_valid}, 64'd0);
        check_eq("t7_long_wait_busy", {63'b0, busy}, 64'd1);
        unit_valid = 4'b1000;
        tick();
        unit_valid = '0;
        check_eq("t7_late_strobe_valid", {63'b0, res_valid}, 64'd1);
        tick();
`endif

        repeat (3) tick();
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Parametrised, registered result-collection stage for the floating-point ALU.
- Accepts one operation select per transaction and waits for the selected arithmetic unit (or the comparator) to report completion.
- Captures that unit's result or compare flags, then presents them on a valid/ready output port until downstream accepts.
- Replaces the purely combinational result mux; supports multi-cycle units and downstream back-pressure.

Parameters:
- WIDTH, 32, result data width in bits.
- NUM_UNITS, 4, number of arithmetic result sources. Unit i is selected by op == i.
- OP_W, 3, width of op. Must satisfy 2**OP_W > NUM_UNITS.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit. Used only when CMP_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- op_valid  input  1  operation request valid.
- op_ready  output  1  collector can accept a request.
- op  input  OP_W  source select: 0..NUM_UNITS-1 = arithmetic unit; NUM_UNITS = compare.
- unit_valid  input  NUM_UNITS  per-unit result-done strobe.
- unit_data  input  NUM_UNITS*WIDTH  per-unit results; unit i occupies bits [i*WIDTH +: WIDTH].
- cmp_valid  input  1  comparator result-done strobe.
- cg, cl, ce  input  1 each  comparator greater / less / equal flags.
- res_valid  output  1  result held and valid.
- res_ready  input  1  downstream accepts result.
- z  output  WIDTH  captured arithmetic result.
- gr, ls, eq  output  1 each  captured compare flags.
- res_op  output  OP_W  op of the transaction being presented.
- err  output  1  invalid op (or timeout when the feature is compiled in).
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset: rst sampled high forces state IDLE; z=0, gr=ls=eq=0, res_op=0, err=0, res_valid=0, busy=0, op_ready=1 in the cycle after reset. Reset mid-transaction discards the transaction; any in-flight unit_valid is ignored.
- States: IDLE, WAIT, RESP.
- op_ready=1 only in IDLE. res_valid=1 only in RESP. busy = (state != IDLE).
- IDLE: on op_valid, latch op into res_op and clear z, gr, ls, eq, err to 0.
  - op <= NUM_UNITS: go to WAIT.
  - op > NUM_UNITS: set err=1 and go directly to RESP.
- WAIT: only the selected source is sampled.
  - Arithmetic op: when unit_valid[res_op]=1, capture z = unit_data slice res_op; flags stay 0; go to RESP.
  - Compare op: when cmp_valid=1, capture gr=cg, ls=cl, eq=ce; z stays 0; go to RESP.
  - Strobes from non-selected sources are ignored and not buffered.
  - A strobe asserted in the same cycle the op is accepted is not seen; sampling starts the cycle after acceptance.
- RESP: z, flags, res_op and err hold stable while res_valid=1. On res_valid && res_ready, go to IDLE; outputs keep their values until the next op is accepted.
- Throughput: no back-to-back overlap. The earliest new acceptance is the cycle after the RESP handshake.
- Latency: op accepted at edge 0, selected strobe high in cycle k (k>=1) -> res_valid high from edge k+1. res_ready held high -> back in IDLE at edge k+2.
- Flags are copied verbatim; no consistency check on cg/cl/ce.

Optional Feature:
- Macro CMP_TIMEOUT_EN.
- Defined: a counter (width clog2(TIMEOUT_CYCLES+1)) clears on op acceptance and increments each WAIT cycle. If the selected strobe is absent for TIMEOUT_CYCLES WAIT cycles, go to RESP with z=0, flags 0, err=1. If the strobe arrives in the same cycle the limit is reached, the strobe wins: normal capture, err=0.
- Not defined: no counter exists; WAIT holds indefinitely until the selected strobe or rst.

Test Plan:
- Reset, then op=1, unit_data slice 1 = 0x40490FDB, unit_valid=4'b0010 three cycles after acceptance, res_ready=1 -> res_valid one cycle after the strobe; z=0x40490FDB, res_op=1, flags 0, err 0; op_ready back after the handshake.
- op=4 (compare), cmp_valid with cg=0, cl=1, ce=0 -> gr=0, ls=1, eq=0, z=0, err=0.
- op=2, unit_valid=4'b0001 (wrong unit) for 5 cycles, then 4'b0100 with data 0xC0000000 -> capture only on the 4'b0100 cycle; z=0xC0000000.
- op=0 captured with z=0x3F800000, res_ready=0 for 6 cycles -> res_valid, z, res_op stable all 6 cycles; op_valid pulses meanwhile ignored (op_ready=0); IDLE after res_ready=1.
- op=7 with NUM_UNITS=4 -> RESP next cycle, err=1, z=0. Separately, assert rst during WAIT -> all outputs at reset values, op_ready=1, and a later unit_valid yields no res_valid.
- With CMP_TIMEOUT_EN, TIMEOUT_CYCLES=8: op=3 and no strobe -> res_valid after 8 WAIT cycles with err=1, z=0. Strobe exactly on the 8th WAIT cycle -> normal capture, err=0.
